bp437dec4: RTL

- Syndrome-feedback decoder for the (4,3,7) Berlekamp-Preparata rate-3/4 convolutional code with 4-way interleaving.
- Sits at the receive end of the bp437enc4 link and recovers the 3-bit data stream from received 4-bit codewords.
- Corrects any single-block burst (16 bits across the interleave) that is followed by a 112-bit guard space.
- Reports corrections, uncorrectable events and a saturating correction count.

---
 rtl/bp437_pkg.sv | 28 ++
 rtl/bp437_reenc4.sv | 40 ++++
 rtl/bp437dec4.sv | 123 ++++++++++++
 3 files changed

// File: rtl/bp437_pkg.sv
// Shared constants, encoder tap sets and error-signature helper for the
// (4,3,7) Berlekamp-Preparata code with 4-way interleaving.
package bp437_pkg;

    localparam int unsigned INTLV = 4;
    localparam int unsigned K     = 7;
    localparam int unsigned DEPTH = INTLV * K;

    // Bit j set means the input contributes to parity j*INTLV symbols later.
    localparam logic [K:0] G2_TAPS = 8'b1000_0010;
    localparam logic [K:0] G1_TAPS = 8'b1100_0100;
    localparam logic [K:0] G0_TAPS = 8'b1110_1000;

    // Syndrome window produced by error pattern e = {parity, u2, u1, u0}.
    function automatic logic [K:0] bp_sig(input logic [3:0] e);
        logic [K:0] s;
        s    = '0;
        s[0] = e[3];
        s[1] = e[2];
        s[2] = e[1];
        s[3] = e[0];
        s[5] = e[0];
        s[6] = e[0] ^ e[1];
        s[7] = e[0] ^ e[1] ^ e[2];
        return s;
    endfunction

endpackage

// File: rtl/bp437_reenc4.sv
// Re-encoder: recomputes the expected parity of the current symbol from
// the raw received data history, using the same taps as the transmitter.
module bp437_reenc4
    import bp437_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [2:0] din,
    output logic       p
);

    logic [DEPTH-1:0][2:0] hist_q, hist_d;

    always_comb begin
        hist_d = hist_q;
        if (ce) begin
            hist_d = {hist_q[DEPTH-2:0], din};
        end
    end

    // hist_q[i] holds din from i+1 symbols ago, so tap j reads index 4j-1.
    always_comb begin
        p = 1'b0;
        for (int unsigned j = 1; j <= K; j++) begin
            if (G2_TAPS[j]) p = p ^ hist_q[INTLV*j-1][2];
            if (G1_TAPS[j]) p = p ^ hist_q[INTLV*j-1][1];
            if (G0_TAPS[j]) p = p ^ hist_q[INTLV*j-1][0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/bp437dec4.sv
// Syndrome-feedback decoder for the interleaved (4,3,7) BP code: syndrome
// window, correction decision, data delay line and status counters.
module bp437dec4
    import bp437_pkg::*;
#(
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic [3:0]      v,
    output logic [2:0]      u,
    output logic            vld,
    output logic            corr,
    output logic            fail,
    input  logic            eclr,
    output logic [CNTW-1:0] ecnt
);

    localparam logic [4:0] WARM = 5'(DEPTH);

    logic                  p;
    logic                  s_now;
    logic [K:0]            win;
    logic [3:0]            e;
    logic [K:0]            sig;
    logic                  do_corr;
    logic                  do_fail;

    logic [DEPTH-1:0]      syn_q, syn_d;
    logic [DEPTH-1:0][2:0] dl_q, dl_d;
    logic [4:0]            wcnt_q, wcnt_d;
    logic [2:0]            u_q, u_d;
    logic                  vld_q, vld_d;
    logic                  corr_q, corr_d;
    logic                  fail_q, fail_d;
    logic [CNTW-1:0]       ecnt_q, ecnt_d;

    bp437_reenc4 u_reenc (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .din (v[2:0]),
        .p   (p)
    );

    assign s_now = v[3] ^ p;

    // Window for the block leaving the delay line: d_j = S(T + 4j).
    always_comb begin
        for (int unsigned j = 0; j < K; j++) begin
            win[j] = syn_q[DEPTH-1-INTLV*j];
        end
        win[K]  = s_now;
        e       = {win[0], win[1], win[2], win[3]};
        sig     = bp_sig(e);
        do_corr = (win == sig) && (e != 4'b0000);
        do_fail = (win != sig) && win[0];
    end

    always_comb begin
        syn_d  = syn_q;
        dl_d   = dl_q;
        wcnt_d = wcnt_q;
        u_d    = u_q;
        vld_d  = vld_q;
        corr_d = corr_q;
        fail_d = fail_q;
        ecnt_d = ecnt_q;
        if (ce) begin
            syn_d = {syn_q[DEPTH-2:0], s_now};
            // Cancel the corrected block's contribution as the window shifts.
            if (do_corr) begin
                for (int unsigned j = 1; j <= K; j++) begin
                    syn_d[DEPTH-INTLV*j] = syn_d[DEPTH-INTLV*j] ^ sig[j];
                end
            end
            dl_d   = {dl_q[DEPTH-2:0], v[2:0]};
            u_d    = dl_q[DEPTH-1] ^ (do_corr ? e[2:0] : 3'b000);
            corr_d = do_corr;
            fail_d = do_fail;
            vld_d  = (wcnt_q == WARM);
            if (wcnt_q != WARM) begin
                wcnt_d = wcnt_q + 5'd1;
            end
            if (do_corr && (ecnt_q != '1)) begin
                ecnt_d = ecnt_q + CNTW'(1);
            end
        end
        if (eclr) begin
            ecnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            syn_q  <= '0;
            dl_q   <= '0;
            wcnt_q <= '0;
            u_q    <= '0;
            vld_q  <= 1'b0;
            corr_q <= 1'b0;
            fail_q <= 1'b0;
            ecnt_q <= '0;
        end else begin
            syn_q  <= syn_d;
            dl_q   <= dl_d;
            wcnt_q <= wcnt_d;
            u_q    <= u_d;
            vld_q  <= vld_d;
            corr_q <= corr_d;
            fail_q <= fail_d;
            ecnt_q <= ecnt_d;
        end
    end

    assign u    = u_q;
    assign vld  = vld_q;
    assign corr = corr_q;
    assign fail = fail_q;
    assign ecnt = ecnt_q;

endmodule
